// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on operands and result; optional iterative MUL (ALU_SEQ_MUL_EN).
// Latency: 1-cycle ops give out_valid after the accepting edge; MUL spends WIDTH cycles in EXEC before HOLD.
// Backpressure: the result waits in HOLD until out_ready; in_ready is low in EXEC and in HOLD without out_ready.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] reg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             c,
  output logic             n,
  output logic             v,
  output logic             busy
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, EXEC = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH + 1);
`else
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
`endif

  state_t state_q, state_d, start_state;
  logic   accept;

  logic [WIDTH-1:0] alu_res;
  logic             alu_z, alu_c, alu_n, alu_v;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] pop;

  assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);

`ifdef ALU_SEQ_MUL_EN
  logic               is_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] mcand_q, prod_q, prod_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  assign is_mul      = (op == 4'b1011);
  assign start_state = is_mul ? EXEC : HOLD;
  assign busy        = (state_q == EXEC);
  assign prod_nxt    = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
  // The counter is about to reach zero on this edge, so the final partial product lands now.
  assign mul_last    = (state_q == EXEC) & (cnt_q == CW'(1));

  // Shift-add multiplier: one multiplier bit per EXEC edge, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept & is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, acc_in};
      prod_q   <= '0;
      mplier_q <= reg_in;
      cnt_q    <= CW'(WIDTH);
    end else if (state_q == EXEC) begin
      prod_q   <= prod_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end
`else
  assign start_state = HOLD;
  assign busy        = 1'b0;
`endif

  // State register; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start new work on accept, leave HOLD only when the result is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = start_state;
      HOLD: if (out_ready) state_d = in_valid ? start_state : IDLE;
`ifdef ALU_SEQ_MUL_EN
      EXEC: if (cnt_q == CW'(1)) state_d = HOLD;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle result and flags for the presented opcode.
  always_comb begin
    alu_res = '0;
    alu_z   = 1'b0;
    alu_c   = 1'b0;
    alu_n   = 1'b0;
    alu_v   = 1'b0;
    wide    = '0;
    pop     = '0;
    case (op)
      4'b0010: begin
        wide    = {1'b0, acc_in} + {1'b0, reg_in};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (acc_in[WIDTH-1] == reg_in[WIDTH-1]) & (alu_res[WIDTH-1] != acc_in[WIDTH-1]);
      end
      4'b0011: begin
        wide    = {1'b0, acc_in} - {1'b0, reg_in};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (acc_in[WIDTH-1] != reg_in[WIDTH-1]) & (alu_res[WIDTH-1] != acc_in[WIDTH-1]);
      end
      4'b0100: alu_res = (reg_in >= WIDTH'(WIDTH)) ? '0 : (acc_in << reg_in);
      4'b0101: alu_res = (reg_in >= WIDTH'(WIDTH)) ? '0 : (acc_in >> reg_in);
      4'b0110: alu_res = acc_in & reg_in;
      4'b0111: alu_res = acc_in | reg_in;
      4'b1000: alu_res = acc_in ^ reg_in;
      4'b1001: begin
        for (int i = 0; i < WIDTH; i++) pop = pop + {{(WIDTH-1){1'b0}}, reg_in[i]};
        alu_res = pop;
      end
      default: alu_res = '0;
    endcase
    if (op == 4'b1010) begin
      // Unsigned compare reports through flags only.
      alu_z = (acc_in == reg_in);
      alu_n = (acc_in < reg_in);
    end else if (op >= 4'b0010 && op <= 4'b1001) begin
      alu_z = (alu_res == '0);
      alu_n = alu_res[WIDTH-1];
    end
  end

  // Result/flag registers: loaded on a 1-cycle accept or MUL completion, otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      z   <= 1'b0;
      c   <= 1'b0;
      n   <= 1'b0;
      v   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
    end else if (accept & ~is_mul) begin
`else
    end else if (accept) begin
`endif
      out <= alu_res;
      z   <= alu_z;
      c   <= alu_c;
      n   <= alu_n;
      v   <= alu_v;
`ifdef ALU_SEQ_MUL_EN
    end else if (mul_last) begin
      out <= prod_nxt[WIDTH-1:0];
      z   <= (prod_nxt[WIDTH-1:0] == '0);
      c   <= |prod_nxt[2*WIDTH-1:WIDTH];
      n   <= prod_nxt[WIDTH-1];
      v   <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): reset, each opcode, back-to-back, back-pressure, MUL/reset-in-EXEC.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op;
  logic [7:0] acc_in;
  logic [7:0] reg_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       z, c, n, v;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_in(acc_in), .reg_in(reg_in), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .z(z), .c(c), .n(n), .v(v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    op       = o;
    acc_in   = a;
    reg_in   = b;
  endtask

  // Result check: out, {z,c,n,v} and out_valid.
  task automatic chk_res(input string tag, input logic [7:0] e_out, input logic [3:0] e_flags);
    chk({tag, "_out"}, 32'(out), 32'(e_out));
    chk({tag, "_flags"}, 32'({z, c, n, v}), 32'(e_flags));
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; op = 4'h0; acc_in = 8'h00; reg_in = 8'h00; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_flags", 32'({z, c, n, v}), 32'h0);
    chk("rst_vld", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", 32'(in_ready), 32'h1);

    // ADD overflow, then hold the result under back-pressure.
    drive(4'b0010, 8'h7F, 8'h01);
    tick();
    chk_res("add_ovf", 8'h80, 4'b0011);
    chk("hold_rdy0", 32'(in_ready), 32'h0);
    drive(4'b0011, 8'h03, 8'h05);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_res("bp_stable", 8'h80, 4'b0011);
      chk("bp_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("hold_rdy1", 32'(in_ready), 32'h1);

    // Back-to-back stream, one result per cycle.
    tick(); chk_res("sub_borrow", 8'hFE, 4'b0110);
    drive(4'b1010, 8'h42, 8'h42); tick(); chk_res("cmp_eq", 8'h00, 4'b1000);
    drive(4'b0100, 8'h81, 8'h09); tick(); chk_res("shl_big", 8'h00, 4'b1000);
    drive(4'b1001, 8'h00, 8'hB7); tick(); chk_res("popcnt", 8'h06, 4'b0000);
    drive(4'b0101, 8'h80, 8'h03); tick(); chk_res("shr", 8'h10, 4'b0000);
    drive(4'b0110, 8'hF0, 8'h3C); tick(); chk_res("and", 8'h30, 4'b0000);
    drive(4'b0111, 8'hF0, 8'h0F); tick(); chk_res("or", 8'hFF, 4'b0010);
    drive(4'b1000, 8'hFF, 8'hFF); tick(); chk_res("xor", 8'h00, 4'b1000);
    drive(4'b0011, 8'h80, 8'h01); tick(); chk_res("sub_ovf", 8'h7F, 4'b0001);
    drive(4'b0010, 8'hFF, 8'h01); tick(); chk_res("add_carry", 8'h00, 4'b1100);
    drive(4'b0000, 8'hFF, 8'hFF); tick(); chk_res("illegal", 8'h00, 4'b0000);
    drive(4'b1010, 8'h01, 8'h02); tick(); chk_res("cmp_lt", 8'h00, 4'b0010);
    drive(4'b0100, 8'h01, 8'h07); tick(); chk_res("shl7", 8'h80, 4'b0010);
    in_valid = 1'b0;
    tick();
    chk("to_idle_vld", 32'(out_valid), 32'h0);
    chk("idle_keep_out", 32'(out), 32'h80);
    chk("idle_rdy2", 32'(in_ready), 32'h1);

`ifdef ALU_SEQ_MUL_EN
    // Iterative multiply: 8 EXEC cycles, busy high and in_ready low throughout.
    out_ready = 1'b0;
    drive(4'b1011, 8'h10, 8'h11);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      chk("mul_rdy0", 32'(in_ready), 32'h0);
      chk("mul_vld0", 32'(out_valid), 32'h0);
      cyc++;
      tick();
    end
    chk("mul_cycles", 32'(cyc), 32'd8);
    chk("mul_busy_off", 32'(busy), 32'h0);
    chk_res("mul", 8'h10, 4'b0100);
    out_ready = 1'b1;
    tick();
    chk("mul_idle", 32'(out_valid), 32'h0);

    // Reset in the middle of EXEC aborts the multiply.
    drive(4'b1011, 8'h0F, 8'h0F);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("exec_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("exec_rst_busy", 32'(busy), 32'h0);
    chk("exec_rst_vld", 32'(out_valid), 32'h0);
    chk("exec_rst_out", 32'(out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("exec_rst_rdy", 32'(in_ready), 32'h1);
    chk("exec_rst_stay", 32'(busy), 32'h0);
`else
    // Without the multiplier, 1011 behaves as an unassigned opcode.
    drive(4'b1011, 8'h10, 8'h11);
    tick();
    in_valid = 1'b0;
    chk_res("mul_off", 8'h00, 4'b0000);
    chk("mul_off_busy", 32'(busy), 32'h0);
    tick();
`endif

    // Reset while a nonzero result is held.
    out_ready = 1'b0;
    drive(4'b0010, 8'h7F, 8'h01);
    tick();
    in_valid = 1'b0;
    chk_res("pre_rst", 8'h80, 4'b0011);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(out), 32'h0);
    chk("mid_rst_flags", 32'({z, c, n, v}), 32'h0);
    chk("mid_rst_vld", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", 32'(in_ready), 32'h1);
    chk("post_rst_vld", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
